// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: squaring-unit state type, format constants and
// a subnormal normalisation helper.
package fp16_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fp16_sq_state_t;

    localparam int          FP16_BIAS     = 15;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;
    localparam logic [15:0] FP16_PINF     = 16'h7C00;
    localparam logic [15:0] FP16_MIN_NORM = 16'h0400;

    // Last value of the shift-add step counter (11 steps: 0..10).
    localparam logic [3:0]  MUL_LAST      = 4'd10;

    // Left shift that brings the top set bit of {1'b0, man} to bit 10.
    // Only meaningful for a nonzero mantissa; result is 1..10.
    function automatic logic [3:0] fp16_sub_lz(input logic [9:0] man);
        logic [3:0] lz;
        lz = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (man[i]) lz = 4'(10 - i);
        end
        return lz;
    endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Packs a 22-bit significand product and a signed biased exponent into
// FP16 with round-to-nearest-even, overflow to +inf and gradual underflow.
// Purely combinational so other FP16 multipliers can reuse it.
module fp16_round_pack
    import fp16_pkg::*;
#(
    parameter bit FLUSH_SUBNORMAL = 1'b0
) (
    input  logic [21:0]       prod,
    input  logic signed [6:0] exp_b,
    output logic [15:0]       result
);

    // Increment m when the discarded part is above half an ulp, or exactly
    // half and m is odd.
    function automatic logic [10:0] rne(input logic [10:0] m, input logic g, input logic s);
        return m + {10'd0, g & (s | m[0])};
    endfunction

    logic              n;
    logic [10:0]       sig;
    logic              guard;
    logic              sticky;
    logic [10:0]       norm_rnd;
    logic signed [6:0] exp_rnd;
    logic signed [6:0] dn_shift;
    logic [23:0]       dn_val;
    logic [10:0]       sub_rnd;

    // Select the 11 significant bits, round both the normal and the
    // denormalised candidate, then pick the one the exponent calls for.
    always_comb begin
        n        = prod[21];
        sig      = n ? prod[21:11] : prod[20:10];
        guard    = n ? prod[10] : prod[9];
        sticky   = n ? (|prod[9:0]) : (|prod[8:0]);

        // Normal path: a carry out of the 10-bit mantissa bumps the exponent
        // and leaves the mantissa bits at zero.
        norm_rnd = rne({1'b0, sig[9:0]}, guard, sticky);
        exp_rnd  = exp_b + $signed({6'd0, norm_rnd[10]});

        // Subnormal path: align to the 2^-24 grid; bits below the guard
        // position fold into sticky. Only the low shift bits matter when
        // the shift is within range.
        dn_shift = 7'sd1 - exp_b;
        dn_val   = {sig, guard, 12'd0} >> dn_shift[3:0];
        sub_rnd  = rne(dn_val[23:13], dn_val[12], sticky | (|dn_val[11:0]));

        result   = 16'h0000;
        if (exp_b >= 7'sd1) begin
            if (exp_rnd >= 7'sd31) begin
                result = FP16_PINF;
            end else begin
                result = {1'b0, exp_rnd[4:0], norm_rnd[9:0]};
            end
        end else if (FLUSH_SUBNORMAL || (dn_shift > 7'sd12)) begin
            result = 16'h0000;
        end else if (sub_rnd[10]) begin
            result = FP16_MIN_NORM;
        end else begin
            result = {6'd0, sub_rnd[9:0]};
        end
    end

endmodule

// File: rtl/fp16_square.sv
// Iterative FP16 squaring unit: specials decoded at acceptance, an 11-step
// shift-add significand multiply, one packing cycle, and a held result with
// valid/ready handshakes on both sides.
module fp16_square
    import fp16_pkg::*;
#(
    parameter bit FLUSH_SUBNORMAL = 1'b0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        valid_data_in,
    output logic        in_ready,
    input  logic [15:0] input_val,
    output logic [15:0] output_val,
    output logic        valid_data_out,
    input  logic        out_ready
);

    fp16_sq_state_t    state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [21:0]       acc_q, acc_d;
    logic [15:0]       res_q, res_d;
    logic [10:0]       sig_q, sig_d;
    logic signed [5:0] e_q, e_d;

    logic [14:0]       mag_in;
    logic [4:0]        exp_in;
    logic [9:0]        man_in;
    logic              is_special;
    logic [15:0]       spec_res;
    logic [3:0]        lz;
    logic [10:0]       unp_sig;
    logic signed [5:0] unp_e;
    logic              accept;
    logic signed [6:0] exp_b;
    logic [15:0]       pack_res;

    assign in_ready       = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign valid_data_out = (state_q == DONE);
    assign output_val     = res_q;
    assign accept         = valid_data_in && in_ready;

    // Decode the incoming operand: the sign never matters for a square, so
    // only the magnitude is inspected.
    always_comb begin
        mag_in     = 15'(input_val & 16'h7FFF);
        exp_in     = mag_in[14:10];
        man_in     = mag_in[9:0];
        is_special = (exp_in == 5'h1F) || (mag_in == 15'd0);
        if (exp_in == 5'h1F) begin
            spec_res = (man_in != 10'd0) ? FP16_QNAN : FP16_PINF;
        end else begin
            spec_res = 16'h0000;
        end
        lz = fp16_sub_lz(man_in);
        if (exp_in == 5'd0) begin
            unp_sig = {1'b0, man_in} << lz;
            unp_e   = -6'sd14 - $signed({2'b00, lz});
        end else begin
            unp_sig = {1'b1, man_in};
            unp_e   = $signed({1'b0, exp_in}) - $signed(6'(FP16_BIAS));
        end
    end

    // Biased result exponent: 2e + product overflow bit + bias.
    always_comb begin
        exp_b = ($signed({e_q[5], e_q}) <<< 1) + $signed({6'd0, acc_q[21]})
                + $signed(7'(FP16_BIAS));
    end

    fp16_round_pack #(
        .FLUSH_SUBNORMAL(FLUSH_SUBNORMAL)
    ) u_round_pack (
        .prod  (acc_q),
        .exp_b (exp_b),
        .result(pack_res)
    );

    // Next-state logic: accept, multiply step, pack, hold until retired.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        sig_d   = sig_q;
        e_d     = e_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (is_special) begin
                        res_d   = spec_res;
                        state_d = DONE;
                    end else begin
                        sig_d   = unp_sig;
                        e_d     = unp_e;
                        acc_d   = 22'd0;
                        cnt_d   = 4'd0;
                        state_d = MUL;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                // Multiplier and multiplicand are the same significand.
                if (sig_q[cnt_q]) begin
                    acc_d = acc_q + ({11'd0, sig_q} << cnt_q);
                end
                if (cnt_q == MUL_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                res_d   = pack_res;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control, accumulator and result registers; reset aborts any operation.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            acc_q   <= 22'd0;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    // Unpacked operand; only read while MUL/ROUND are active.
    always_ff @(posedge CLK) begin
        sig_q <= sig_d;
        e_q   <= e_d;
    end

endmodule

// File: tb/tb_fp16_square.sv
// Bench for fp16_square: two instances (gradual underflow and flush) run in
// lockstep against an exact-arithmetic FP16 squaring model with a latency
// scoreboard; directed values pin the model, random traffic exercises it.
module tb_fp16_square;

    bit          CLK;
    logic        nRST;
    logic        valid_data_in;
    logic        out_ready;
    logic [15:0] input_val;
    logic        in_ready, valid_data_out;
    logic [15:0] output_val;
    logic        f_in_ready, f_valid_data_out;
    logic [15:0] f_output_val;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] q_res[$];
    logic [15:0] q_resf[$];
    int          q_due[$];
    logic [15:0] last_out = 16'h0000;
    logic [15:0] last_outf = 16'h0000;
    bit          mon_valid, mon_ready;

    fp16_square #(.FLUSH_SUBNORMAL(1'b0)) u_dut (
        .CLK(CLK), .nRST(nRST), .valid_data_in(valid_data_in), .in_ready(in_ready),
        .input_val(input_val), .output_val(output_val),
        .valid_data_out(valid_data_out), .out_ready(out_ready)
    );

    fp16_square #(.FLUSH_SUBNORMAL(1'b1)) u_flush (
        .CLK(CLK), .nRST(nRST), .valid_data_in(valid_data_in), .in_ready(f_in_ready),
        .input_val(input_val), .output_val(f_output_val),
        .valid_data_out(f_valid_data_out), .out_ready(out_ready)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required run to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_spec(input logic [15:0] x);
        return (x[14:10] == 5'h1F) || (x[14:0] == 15'd0);
    endfunction

    // Exact model: operand = (+/-)M * 2^k, square = M^2 * 2^(2k), then
    // quantise to the FP16 grid at the value's own binade with RNE.
    function automatic logic [15:0] model_sq(input logic [15:0] x, input bit flush);
        int     ex, k, q, b, ulp, sh, ef;
        longint mant, p, m, rem, half;
        ex   = int'(x[14:10]);
        mant = longint'(x[9:0]);
        if (ex == 31) return (mant != 0) ? 16'h7E00 : 16'h7C00;
        if (ex == 0 && mant == 0) return 16'h0000;
        if (ex == 0) begin
            k = -24;
        end else begin
            mant = mant + 1024;
            k    = ex - 25;
        end
        if (x[15]) mant = -mant;
        p = mant * mant;
        q = 2 * k;
        b = 0;
        for (int i = 0; i < 40; i++) if (((p >> i) & 1) == 1) b = i;
        if (flush && (b + q) < -14) return 16'h0000;
        ulp = (b + q >= -14) ? (b + q - 10) : -24;
        sh  = ulp - q;
        if (sh <= 0) begin
            m = p << (-sh);
        end else begin
            m    = p >> sh;
            rem  = p - (m << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
        end
        if (m == 2048) begin
            m   = 1024;
            ulp = ulp + 1;
        end
        if (ulp == -24 && m < 1024) return 16'(m);
        ef = ulp + 25;
        if (ef >= 31) return 16'h7C00;
        return {1'b0, 5'(ef), 10'(m)};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] r;
        r        = 16'($urandom);
        r[14:10] = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) r[9:0] = 10'd0;
        return r;
    endfunction

    // Scoreboard: every cycle, both instances against the model's handshake
    // and held-result expectations.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (!nRST) begin
            q_res.delete();
            q_resf.delete();
            q_due.delete();
            last_out  = 16'h0000;
            last_outf = 16'h0000;
            chk("reset_valid", 32'(valid_data_out), 32'd0);
            chk("reset_in_ready", 32'(in_ready), 32'd1);
            chk("reset_output", 32'(output_val), 32'd0);
            chk("reset_output_flush", 32'(f_output_val), 32'd0);
        end else begin
            mon_valid = (q_due.size() > 0) && (cyc >= q_due[0]);
            if (mon_valid) begin
                last_out  = q_res[0];
                last_outf = q_resf[0];
            end
            mon_ready = (q_due.size() == 0) || (mon_valid && out_ready);
            chk("valid", 32'(valid_data_out), 32'(mon_valid));
            chk("valid_flush", 32'(f_valid_data_out), 32'(mon_valid));
            chk("in_ready", 32'(in_ready), 32'(mon_ready));
            chk("in_ready_flush", 32'(f_in_ready), 32'(mon_ready));
            chk("output", 32'(output_val), 32'(last_out));
            chk("output_flush", 32'(f_output_val), 32'(last_outf));
            if (mon_valid && out_ready) begin
                void'(q_res.pop_front());
                void'(q_resf.pop_front());
                void'(q_due.pop_front());
            end
            if (valid_data_in && mon_ready) begin
                q_res.push_back(model_sq(input_val, 1'b0));
                q_resf.push_back(model_sq(input_val, 1'b1));
                q_due.push_back(cyc + (is_spec(input_val) ? 1 : 13));
            end
        end
    end

    // Offer x until accepted (bounded), then drop valid.
    task automatic send(input logic [15:0] x);
        bit acc;
        int w;
        @(posedge CLK);
        #1;
        valid_data_in = 1'b1;
        input_val     = x;
        acc = 1'b0;
        w   = 0;
        while (!acc && w < 40) begin
            @(negedge CLK);
            if (in_ready) acc = 1'b1;
            w++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        valid_data_in = 1'b0;
        input_val     = 16'($urandom);
    endtask

    // Count negedges from the transfer edge until valid_data_out shows.
    task automatic wait_valid(output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge CLK);
            n++;
            if (valid_data_out) seen = 1'b1;
        end
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] r, input logic [15:0] rf,
                          input int lat);
        int n;
        chk($sformatf("model_%h", x), 32'(model_sq(x, 1'b0)), 32'(r));
        chk($sformatf("model_flush_%h", x), 32'(model_sq(x, 1'b1)), 32'(rf));
        out_ready = 1'b1;
        send(x);
        wait_valid(n);
        chk($sformatf("latency_%h", x), 32'(n), 32'(lat));
        chk($sformatf("result_%h", x), 32'(output_val), 32'(r));
        chk($sformatf("result_flush_%h", x), 32'(f_output_val), 32'(rf));
    endtask

    initial begin
        int n;
        nRST          = 1'b0;
        valid_data_in = 1'b0;
        input_val     = 16'h0000;
        out_ready     = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("init_valid", 32'(valid_data_out), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_output", 32'(output_val), 32'd0);
        nRST = 1'b1;

        // Directed values with hand-computed results.
        run_op(16'h3C00, 16'h3C00, 16'h3C00, 13);
        run_op(16'h3E00, 16'h4080, 16'h4080, 13);
        run_op(16'hBC00, 16'h3C00, 16'h3C00, 13);
        run_op(16'h7C01, 16'h7E00, 16'h7E00, 1);
        run_op(16'hFC00, 16'h7C00, 16'h7C00, 1);
        run_op(16'h8000, 16'h0000, 16'h0000, 1);
        run_op(16'h5C00, 16'h7C00, 16'h7C00, 13);
        run_op(16'h1400, 16'h0010, 16'h0000, 13);
        run_op(16'h0800, 16'h0000, 16'h0000, 13);
        run_op(16'h0001, 16'h0000, 16'h0000, 13);
        run_op(16'h3C01, 16'h3C02, 16'h3C02, 13);

        // Backpressure: result held, then retire and accept in one edge.
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        send(16'h3E00);
        wait_valid(n);
        chk("bp_latency", 32'(n), 32'd13);
        repeat (5) begin
            @(negedge CLK);
            chk("bp_hold_output", 32'(output_val), 32'h4080);
            chk("bp_hold_valid", 32'(valid_data_out), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge CLK);
        #1;
        out_ready     = 1'b1;
        valid_data_in = 1'b1;
        input_val     = 16'h4000;
        @(negedge CLK);
        chk("bp_in_ready_same_cycle", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        valid_data_in = 1'b0;
        wait_valid(n);
        chk("bp_next_latency", 32'(n), 32'd13);
        chk("bp_next_result", 32'(output_val), 32'h4400);

        // Reset during MUL aborts the operation.
        send(16'h4000);
        repeat (6) @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        chk("abort_valid", 32'(valid_data_out), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_output", 32'(output_val), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        run_op(16'h4000, 16'h4400, 16'h4400, 13);

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK);
            #1;
            valid_data_in = ($urandom_range(0, 2) != 0);
            input_val     = rand_op();
            out_ready     = ($urandom_range(0, 3) != 0);
        end
        @(posedge CLK);
        #1;
        valid_data_in = 1'b0;
        out_ready     = 1'b1;
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        chk("drain_empty", 32'(q_due.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
